// File: rtl/elevator_call_panel.sv
// Button front end for the elevator controller: synchronizes and debounces the 8 raw
// buttons, latches presses as level requests and clears them when the floor is served.
// Optional build macro CAR_CANCEL_EN: re-pressing a latched car button cancels it.
module elevator_call_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_car,
    input  logic [3:0] btn_hall,
    input  logic [1:0] prox,
    input  logic       door_open,
    input  logic       door_closed,
    input  logic       firealarm,
    output logic [3:0] car_req,
    output logic [3:0] hall_req,
    output logic       any_pending
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);

    // Bits 0..3 are car buttons, bits 4..7 hall buttons, both indexed by floor.
    logic [7:0] raw;
    logic [7:0] press;

    assign raw = {btn_hall, btn_car};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             st_q;
            logic             st_d;
            logic             st_prev_q;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                st_d  = st_q;
                cnt_d = '0;
                if (sync2_q != st_q) begin
                    if (cnt_q + CNT_W'(1) == DEB_LAST) begin
                        st_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    st_q      <= 1'b0;
                    st_prev_q <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= raw[gi];
                    sync2_q   <= sync1_q;
                    st_q      <= st_d;
                    st_prev_q <= st_q;
                    cnt_q     <= cnt_d;
                end
            end

            // Only the rising edge of the debounced level is a press; releases are ignored.
            assign press[gi] = st_q & ~st_prev_q;
        end
    endgenerate

    logic [3:0] serve;
    logic [3:0] car_req_q;
    logic [3:0] car_req_d;
    logic [3:0] hall_req_q;
    logic [3:0] hall_req_d;
    logic       any_pending_q;

    always_comb begin
        serve      = '0;
        car_req_d  = car_req_q;
        hall_req_d = hall_req_q;
        for (int k = 0; k < 4; k++) begin
            serve[k] = door_open & ~door_closed & (prox == 2'(k));
            // Service clear outranks everything, so a press at a served floor is lost.
            if (serve[k]) begin
                car_req_d[k]  = 1'b0;
                hall_req_d[k] = 1'b0;
            end else begin
                if (press[k]) begin
`ifdef CAR_CANCEL_EN
                    car_req_d[k] = ~car_req_q[k];
`else
                    car_req_d[k] = 1'b1;
`endif
                end
                if (firealarm) begin
                    hall_req_d[k] = 1'b0;
                end else if (press[k+4]) begin
                    hall_req_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_req_q     <= '0;
            hall_req_q    <= '0;
            any_pending_q <= 1'b0;
        end else begin
            car_req_q     <= car_req_d;
            hall_req_q    <= hall_req_d;
            any_pending_q <= |{car_req_d, hall_req_d};
        end
    end

    assign car_req     = car_req_q;
    assign hall_req    = hall_req_q;
    assign any_pending = any_pending_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel with DEBOUNCE_CYCLES=4 (request 6 edges after
// the first edge sampling a press). Honours CAR_CANCEL_EN when defined for the build.
module tb_elevator_call_panel;

    logic       clk;
    logic       reset;
    logic [3:0] btn_car;
    logic [3:0] btn_hall;
    logic [1:0] prox;
    logic       door_open;
    logic       door_closed;
    logic       firealarm;
    logic [3:0] car_req;
    logic [3:0] hall_req;
    logic       any_pending;

    int n_vec;
    int n_err;

    elevator_call_panel #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_car(btn_car),
        .btn_hall(btn_hall),
        .prox(prox),
        .door_open(door_open),
        .door_closed(door_closed),
        .firealarm(firealarm),
        .car_req(car_req),
        .hall_req(hall_req),
        .any_pending(any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
    endtask

    task automatic serve_floor(input logic [1:0] f);
        prox        = f;
        door_open   = 1'b1;
        door_closed = 1'b0;
        step(1);
        door_open   = 1'b0;
        door_closed = 1'b1;
    endtask

    task automatic clear_all();
        for (int f = 0; f < 4; f++) serve_floor(2'(f));
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b0;
        btn_car     = 4'hF;
        btn_hall    = 4'hF;
        prox        = 2'd0;
        door_open   = 1'b0;
        door_closed = 1'b1;
        firealarm   = 1'b0;

        // Reset with every button held
        step(3);
        check("reset_car", {4'h0, car_req}, 8'h00);
        check("reset_hall", {4'h0, hall_req}, 8'h00);
        check("reset_any", {7'h0, any_pending}, 8'h00);
        reset = 1'b1;
        step(6);
        check("rel_car_early", {4'h0, car_req}, 8'h00);
        step(1);
        check("rel_car", {4'h0, car_req}, 8'h0F);
        check("rel_hall", {4'h0, hall_req}, 8'h0F);
        check("rel_any", {7'h0, any_pending}, 8'h01);
        btn_car  = 4'h0;
        btn_hall = 4'h0;
        step(8);
        check("held_after_release", {hall_req, car_req}, 8'hFF);
        clear_all();
        check("clear_all", {hall_req, car_req}, 8'h00);
        check("clear_any", {7'h0, any_pending}, 8'h00);

        // Debounce: 3-cycle glitch rejected, long press accepted
        btn_car[2] = 1'b1;
        step(3);
        btn_car[2] = 1'b0;
        step(10);
        check("glitch", {4'h0, car_req}, 8'h00);
        btn_car[2] = 1'b1;
        step(6);
        check("deb_early", {4'h0, car_req}, 8'h00);
        step(1);
        check("deb_set", {4'h0, car_req}, 8'h04);
        check("deb_any", {7'h0, any_pending}, 8'h01);
        step(3);
        btn_car[2] = 1'b0;
        step(8);
        check("deb_hold", {4'h0, car_req}, 8'h04);

        // Service clear
        serve_floor(2'd2);
        check("clr_f2", {4'h0, car_req}, 8'h00);
        btn_car[3]  = 1'b1;
        btn_hall[1] = 1'b1;
        step(7);
        btn_car[3]  = 1'b0;
        btn_hall[1] = 1'b0;
        step(8);
        check("svc_setup", {hall_req, car_req}, 8'h28);
        prox        = 2'd3;
        door_open   = 1'b1;
        door_closed = 1'b0;
        step(1);
        check("svc_f3", {hall_req, car_req}, 8'h20);
        btn_car[3] = 1'b1;
        step(10);
        btn_car[3] = 1'b0;
        step(8);
        check("svc_press_discard", {hall_req, car_req}, 8'h20);
        prox = 2'd1;
        step(1);
        check("svc_f1", {hall_req, car_req}, 8'h00);
        check("svc_any", {7'h0, any_pending}, 8'h00);
        door_open   = 1'b0;
        door_closed = 1'b1;

        // Fire alarm
        btn_hall = 4'b0101;
        btn_car  = 4'b0010;
        step(7);
        btn_hall = 4'h0;
        btn_car  = 4'h0;
        step(8);
        check("fire_setup", {hall_req, car_req}, 8'h52);
        firealarm = 1'b1;
        step(1);
        check("fire_clear", {hall_req, car_req}, 8'h02);
        btn_hall[1] = 1'b1;
        step(7);
        check("fire_hall_block", {4'h0, hall_req}, 8'h00);
        btn_hall[1] = 1'b0;
        step(8);
        btn_car[0] = 1'b1;
        step(7);
        check("fire_car_ok", {4'h0, car_req}, 8'h03);
        btn_car[0] = 1'b0;
        step(8);
        firealarm   = 1'b0;
        btn_hall[1] = 1'b1;
        step(7);
        check("fire_off_hall", {4'h0, hall_req}, 8'h02);
        btn_hall[1] = 1'b0;
        step(8);
        clear_all();

        // Press debounces while floor 2 is being served
        prox        = 2'd2;
        door_open   = 1'b1;
        door_closed = 1'b0;
        btn_car[2]  = 1'b1;
        btn_hall[2] = 1'b1;
        step(7);
        check("simul_serve", {hall_req, car_req}, 8'h00);
        step(3);
        btn_car[2]  = 1'b0;
        btn_hall[2] = 1'b0;
        step(8);
        door_open   = 1'b0;
        door_closed = 1'b1;
        step(2);
        check("simul_no_defer", {hall_req, car_req}, 8'h00);

        // door_open together with door_closed is not a service
        btn_car[1] = 1'b1;
        step(7);
        btn_car[1] = 1'b0;
        step(8);
        prox      = 2'd1;
        door_open = 1'b1;
        step(2);
        check("both_doors", {4'h0, car_req}, 8'h02);
        door_open = 1'b0;
        clear_all();

        // Asynchronous reset mid-debounce
        btn_car[0] = 1'b1;
        step(7);
        btn_car[0] = 1'b0;
        step(8);
        btn_car[3] = 1'b1;
        step(3);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_car", {4'h0, car_req}, 8'h00);
        check("async_rst_any", {7'h0, any_pending}, 8'h00);
        step(1);
        reset = 1'b1;
        step(6);
        check("rst_redeb_early", {4'h0, car_req}, 8'h00);
        step(1);
        check("rst_redeb", {4'h0, car_req}, 8'h08);
        btn_car[3] = 1'b0;
        step(8);

        // Re-press of latched car and hall requests
        btn_car[1] = 1'b1;
        step(7);
        btn_car[1] = 1'b0;
        step(8);
        check("repress_setup", {4'h0, car_req}, 8'h0A);
        btn_car[1] = 1'b1;
        step(6);
        check("repress_early", {4'h0, car_req}, 8'h0A);
        step(1);
`ifdef CAR_CANCEL_EN
        check("car_repress", {4'h0, car_req}, 8'h08);
`else
        check("car_repress", {4'h0, car_req}, 8'h0A);
`endif
        btn_car[1]  = 1'b0;
        step(8);
        btn_hall[3] = 1'b1;
        step(7);
        btn_hall[3] = 1'b0;
        step(8);
        check("hall_setup", {4'h0, hall_req}, 8'h08);
        btn_hall[3] = 1'b1;
        step(7);
        check("hall_repress", {4'h0, hall_req}, 8'h08);
        btn_hall[3] = 1'b0;
        step(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Front end that produces the elevator controller's request inputs: car buttons BG/BF1/BF2/BF3 and hall calls reqG/reqF1/reqF2/reqF3.
- Synchronizes and debounces 8 raw push-buttons (4 car, 4 hall) and latches each press as a level-held request.
- Reads back the controller's prox/door_open/door_closed outputs to clear a request once that floor is served.
- Sits between the board button pins and the elevator controller, driving its request ports directly.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized-stable cycles required before a button level change is accepted; legal range 1..255.
- CNT_W, 8: width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- btn_car  input  4  raw car buttons, bit k = floor k (0 = ground); asynchronous to clk.
- btn_hall  input  4  raw hall-call buttons, bit k = floor k; asynchronous to clk.
- prox  input  2  current cabin floor from the controller.
- door_open  input  1  controller door-open status.
- door_closed  input  1  controller door-closed status.
- firealarm  input  1  fire alarm, synchronous to clk.
- car_req  output  4  latched car requests; bit0..3 drive BG, BF1, BF2, BF3.
- hall_req  output  4  latched hall calls; bit0..3 drive reqG, reqF1, reqF2, reqF3.
- any_pending  output  1  OR of all car_req and hall_req bits.

Behaviour:
- Reset (reset=0, asynchronous): all synchronizer flops, debounce counters, stable levels, car_req, hall_req and any_pending go to 0. Release is synchronous-safe: first update occurs at the first clk edge after reset=1.
- Per button: 2-flop synchronizer feeds s; stable level register st; counter cnt.
  - If s==st: cnt <= 0.
  - Else cnt <= cnt+1. When cnt+1 == DEBOUNCE_CYCLES: st <= s and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no st change.
- Press event: st rises (st=1, previous st=0). Release events are ignored.
- Latency: raw high first sampled at edge N gives st=1 after edge N+1+DEBOUNCE_CYCLES and the request bit=1 after edge N+2+DEBOUNCE_CYCLES.
- serve[k] = door_open & ~door_closed & (prox==k). This is level-based.
- Request bit k, per cycle, priority highest first:
  1. serve[k] -> 0. Clear wins over a simultaneous press; a press while floor k is being served is discarded.
  2. Hall only: firealarm=1 -> hall_req[k] forced 0; hall presses discarded.
  3. Press event -> 1.
  4. Otherwise hold.
- firealarm does not affect car_req; car requests remain usable by fire service.
- Floors are independent. Any combination of set/clear on different bits in the same cycle applies simultaneously.
- Re-press of an already-latched request: no effect (see Optional Feature).
- Button held continuously: one press event only; a new request requires release (debounced) then press.
- any_pending is registered and updated from the next-state request values, so it is coincident with the request bits.
- door_open=1 together with door_closed=1 is treated as not serving (no clear).

Optional Feature:
- Macro: CAR_CANCEL_EN.
- Defined: a press event on a car button whose car_req bit is already 1 (and not being served) clears that bit. The cancel takes effect in the same latency as a set. Hall calls are never cancellable.
- Undefined: re-press of a latched car request is ignored.

Test Plan:
- Reset: hold reset=0 with all btn bits high -> all outputs 0. After release with DEBOUNCE_CYCLES=4, car_req=4'b1111 and hall_req=4'b1111 appear 6 edges after the first edge sampling the buttons high.
- Debounce: pulse btn_car[2] high for 3 clk cycles -> car_req stays 0. Hold it 10 cycles -> car_req=4'b0100 at N+6 and stays set after release; any_pending=1.
- Service clear: car_req=4'b1000, hall_req=4'b0010. Drive prox=3, door_open=1, door_closed=0 -> car_req=0 next edge, hall_req unchanged. Press btn_car[3] during the open door -> stays 0. Switch to prox=1 -> hall_req=0, any_pending=0.
- Fire alarm: hall_req=4'b0101, car_req=4'b0010, then firealarm=1 -> hall_req=0 next edge, car_req=4'b0010. Press btn_hall[1] under alarm -> no set. Press btn_car[0] -> car_req=4'b0011. Deassert alarm, press btn_hall[1] -> hall_req=4'b0010.
- Simultaneity/async reset: press for floor 2 debounces in the same cycle serve[2] asserts -> bit stays 0. Assert reset mid-debounce -> outputs 0 immediately (no clk edge); after release, a new full debounce is required.
- CAR_CANCEL_EN: car_req[1]=1, re-press btn_car[1] -> defined: car_req[1]=0 at N+6; undefined: stays 1. btn_hall re-press has no effect in either build.
